sample_ram_buffer: RTL
======================

Name: sample_ram_buffer

Overview:
- Circular sample buffer between i2s_capture_24 (upstream, 27 MHz strobe domain) and vu_meter_6led (downstream ready/valid consumer).
- Selects one 24-bit PCM channel, stores it in a simple-dual-port synchronous RAM and serves it one sample at a time over a ready/valid read port.
- Reports fill level, a block-ready flag, and a sticky overflow flag.

Parameters:
- SELECT_LEFT, 1'b1, channel stored: 1 = left_sample_i, 0 = right_sample_i.
- DEPTH, 512, RAM entries; power of 2, range 4..4096.
- READY_THRESHOLD, 256, buffer_ready_o asserts when count >= this value; range 1..DEPTH.
- ADDR_W (localparam), $clog2(DEPTH), pointer width.

Ports:
- clk_i  in  1  system clock, 27 MHz; single clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- left_sample_i  in  24  signed PCM, left channel.
- right_sample_i  in  24  signed PCM, right channel.
- sample_valid_i  in  1  one-cycle strobe from i2s_capture_24 ready_o.
- flush_i  in  1  synchronous flush of all contents.
- clear_overflow_i  in  1  synchronous clear of overflow_o.
- read_data_o  out  24  signed sample presented to the consumer.
- read_valid_o  out  1  read_data_o is valid.
- read_ready_i  in  1  consumer accepts the sample.
- buffer_ready_o  out  1  registered flag: count >= READY_THRESHOLD.
- fill_level_o  out  ADDR_W+1  stored entries not yet fetched (count).
- overflow_o  out  1  sticky flag: a sample was dropped.

Behaviour:
- Reset values: all outputs 0; wr_ptr, rd_ptr and count are 0; FSM in S_IDLE. RAM contents are undefined and need no reset.
- Write path: when sample_valid_i=1 and count<DEPTH, write the selected channel at wr_ptr, then wr_ptr++ (wraps modulo DEPTH).
- Full: when sample_valid_i=1 and count==DEPTH, drop the sample, leave the pointers unchanged and set overflow_o=1. overflow_o stays set until clear_overflow_i or flush_i.
- Overflow and clear in the same cycle: set wins.
- RAM: 1-cycle synchronous read. Read address registered in the issue cycle; data available the next cycle.
- Read FSM, S_IDLE: read_valid_o=0. If count>0, issue a read at rd_ptr, rd_ptr++, count--, and go to S_FETCH.
- Read FSM, S_FETCH: read_valid_o=0. Capture RAM dout into the output register and go to S_VALID.
- Read FSM, S_VALID: read_valid_o=1; read_data_o is held stable until the handshake.
  - Handshake (read_valid_o && read_ready_i) with count>0: issue the next read and go to S_FETCH.
  - Handshake with count==0: go to S_IDLE.
  - No handshake: hold in S_VALID.
- Throughput: at most 1 sample per 2 cycles, which is sufficient because vu_meter_6led accepts at most 1 sample per 3 cycles.
- Latency: with strobe in cycle N into an empty buffer, count=1 in N+1, read issued in N+1, read_valid_o=1 in N+3.
- Simultaneous write and read issue: count is unchanged.
  - A read never targets the slot being written, because count>0 implies the data was committed on an earlier edge.
- count excludes the held output word and any in-flight word. Maximum storage is DEPTH+1 samples.
- buffer_ready_o is registered from next-state count, so it is coincident with fill_level_o.
- flush_i (synchronous, highest priority over write and read):
  - pointers, count and overflow_o go to 0; FSM goes to S_IDLE; read_valid_o=0 on the next cycle.
  - A sample_valid_i in the same cycle is discarded.
- Asynchronous reset mid-transfer: everything returns to reset values immediately; the held sample is lost.
- Width rule: stored data is the raw 24-bit two's complement sample with no scaling.

Decomposition:
- Package sample_buf_pkg:
  - SAMPLE_W=24;
  - typedef logic signed [SAMPLE_W-1:0] sample_t;
  - enum rd_state_e {S_IDLE, S_FETCH, S_VALID}.
- Sub-module sample_sdp_ram:
  - parameterised DEPTH/width; one write port, one registered read port;
  - inferable as Gowin BSRAM; no reset.

Test Plan:
- Single write, SELECT_LEFT=1, left=24'h800001, right=24'h123456, strobe in cycle 0, read_ready_i=1 → read_valid_o=1 in cycle 3 with read_data_o=24'h800001; fill_level_o returns to 0.
- Backpressure: write 3 samples (1, 2, 3) with read_ready_i=0 → read_data_o=1 held stable and read_valid_o steady for 100 cycles; fill_level_o=2. Then read_ready_i=1 → samples 2 and 3 delivered in order, 2 cycles apart.
- Overflow: DEPTH=4, ready low, write 7 samples → fill_level_o=4, 1 word held, 2 dropped, overflow_o=1. clear_overflow_i → 0. Drain → values 1..5 in order.
- Threshold: READY_THRESHOLD=256, write 256 samples with consumer stalled (first is held, so count=255) → buffer_ready_o=0. 257th write → 1 in the cycle fill_level_o=256.
- Wrap-around: DEPTH=4, stream 20 samples at 1 per 3 cycles with read_ready_i=1 → all 20 received in order; no overflow; wr_ptr and rd_ptr wrap 5 times.
- flush_i asserted in S_FETCH with count=2, and again with async reset in S_VALID → next cycle read_valid_o=0, fill_level_o=0, overflow_o=0; a subsequent write returns to the normal 3-cycle latency.

Source files
------------

// File: rtl/sample_buf_pkg.sv
// Shared types for the circular sample buffer: sample word and read-side state encoding.
package sample_buf_pkg;

  localparam int SAMPLE_W = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sample_sdp_ram.sv
// Simple-dual-port synchronous RAM: one write port, one registered read port, no reset
// so that it maps onto block RAM.
module sample_sdp_ram
  import sample_buf_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int WIDTH  = SAMPLE_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_r[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port: data appears the cycle after the read is issued.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_o <= mem_r[rd_addr_i];
    end
  end

endmodule

// File: rtl/sample_ram_buffer.sv
// Circular buffer for one PCM channel: strobed writes into RAM, ready/valid read port,
// fill level, block-ready flag and sticky overflow.
module sample_ram_buffer
  import sample_buf_pkg::*;
#(
  parameter logic SELECT_LEFT     = 1'b1,
  parameter int   DEPTH           = 512,
  parameter int   READY_THRESHOLD = 256,
  localparam int  ADDR_W          = $clog2(DEPTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic signed [SAMPLE_W-1:0] left_sample_i,
  input  logic signed [SAMPLE_W-1:0] right_sample_i,
  input  logic                       sample_valid_i,
  input  logic                       flush_i,
  input  logic                       clear_overflow_i,
  output logic signed [SAMPLE_W-1:0] read_data_o,
  output logic                       read_valid_o,
  input  logic                       read_ready_i,
  output logic                       buffer_ready_o,
  output logic [ADDR_W:0]            fill_level_o,
  output logic                       overflow_o
);

  localparam logic [ADDR_W:0]   CNT_ZERO_C = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE_C  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   THRESH_C   = (ADDR_W+1)'(READY_THRESHOLD);
  localparam logic [ADDR_W-1:0] PTR_ZERO_C = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE_C  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [SAMPLE_W-1:0] DATA_ZERO_C = {SAMPLE_W{1'b0}};

  rd_state_e         state_r, state_nxt_s;
  logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_W:0]   count_r, count_nxt_s;
  logic              wr_en_s, drop_s, rd_issue_s, capture_s, hs_s;
  logic              not_empty_s, full_s;
  sample_t           wr_data_s, ram_dout_s, read_data_r;
  logic              read_valid_r, buffer_ready_r, overflow_r;

  assign wr_data_s   = SELECT_LEFT ? left_sample_i : right_sample_i;
  assign not_empty_s = (count_r != CNT_ZERO_C);
  assign full_s      = (count_r == DEPTH_C);
  assign hs_s        = read_valid_r && read_ready_i;

  // Write acceptance: a strobe is stored unless the RAM is full or a flush wins.
  always_comb begin
    wr_en_s = 1'b0;
    drop_s  = 1'b0;
    if (flush_i) begin
      wr_en_s = 1'b0;
      drop_s  = 1'b0;
    end else if (sample_valid_i) begin
      if (full_s) begin
        drop_s = 1'b1;
      end else begin
        wr_en_s = 1'b1;
      end
    end else begin
      wr_en_s = 1'b0;
      drop_s  = 1'b0;
    end
  end

  // Read-side next state: issue a RAM read, capture its data, then present it until taken.
  always_comb begin
    state_nxt_s = state_r;
    rd_issue_s  = 1'b0;
    capture_s   = 1'b0;
    if (flush_i) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (not_empty_s) begin
            rd_issue_s  = 1'b1;
            state_nxt_s = S_FETCH;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_FETCH: begin
          capture_s   = 1'b1;
          state_nxt_s = S_VALID;
        end
        S_VALID: begin
          if (hs_s) begin
            if (not_empty_s) begin
              rd_issue_s  = 1'b1;
              state_nxt_s = S_FETCH;
            end else begin
              state_nxt_s = S_IDLE;
            end
          end else begin
            state_nxt_s = S_VALID;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // Stored-entry count; a write and a read issue in the same cycle cancel out.
  always_comb begin
    count_nxt_s = count_r;
    if (flush_i) begin
      count_nxt_s = CNT_ZERO_C;
    end else begin
      case ({wr_en_s, rd_issue_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE_C;
        2'b01:   count_nxt_s = count_r - CNT_ONE_C;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // State, pointers and count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= S_IDLE;
      wr_ptr_r <= PTR_ZERO_C;
      rd_ptr_r <= PTR_ZERO_C;
      count_r  <= CNT_ZERO_C;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      if (flush_i) begin
        wr_ptr_r <= PTR_ZERO_C;
        rd_ptr_r <= PTR_ZERO_C;
      end else begin
        if (wr_en_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
        end
        if (rd_issue_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
        end
      end
    end
  end

  // Output registers; overflow set takes priority over its clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_data_r    <= DATA_ZERO_C;
      read_valid_r   <= 1'b0;
      buffer_ready_r <= 1'b0;
      overflow_r     <= 1'b0;
    end else begin
      read_valid_r   <= (state_nxt_s == S_VALID);
      buffer_ready_r <= (count_nxt_s >= THRESH_C);
      if (capture_s) begin
        read_data_r <= ram_dout_s;
      end
      if (flush_i) begin
        overflow_r <= 1'b0;
      end else if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clear_overflow_i) begin
        overflow_r <= 1'b0;
      end
    end
  end

  sample_sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_ptr_r),
    .wr_data_i (wr_data_s),
    .rd_en_i   (rd_issue_s),
    .rd_addr_i (rd_ptr_r),
    .rd_data_o (ram_dout_s)
  );

  assign read_data_o    = read_data_r;
  assign read_valid_o   = read_valid_r;
  assign buffer_ready_o = buffer_ready_r;
  assign fill_level_o   = count_r;
  assign overflow_o     = overflow_r;

endmodule
